// File: rtl/s1_decode_pkg.sv
// Shared constants for the stage-1 decoder: instruction field positions,
// opcode class encoding and default datapath widths.
package s1_decode_pkg;

  localparam int S1_DATA_W   = 32;
  localparam int S1_RADDR_W  = 5;
  localparam int S1_IMM_W    = 16;
  localparam int S1_ALUOP_W  = 3;
  localparam int S1_OPCODE_W = 6;

  localparam int OPC_LSB = 26;
  localparam int RD_LSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int IMM_LSB = 0;

  // Bit positions inside the opcode
  localparam int OPC_CLASS_LSB = 4;
  localparam int OPC_DSRC_BIT  = 3;

  localparam logic [1:0] OPC_CLASS_ALU = 2'b00;

endpackage

// File: rtl/regfile_32x32.sv
// Register file: two async read ports, one sync write port, R0 hard-wired to zero.
// Reads bypass a same-cycle write (write-first); writes are never back-pressured.
module regfile_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_sel1,
  input  logic [ADDR_WIDTH-1:0] read_sel2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] write_sel,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_en && (write_sel != '0)) begin
      regs[write_sel] <= write_data;
    end
  end

  // Write-first bypass so the decode stage sees write-back data without a bubble
  always_comb begin
    read_data1 = regs[read_sel1];
    if (read_sel1 == '0)                            read_data1 = '0;
    else if (write_en && (write_sel == read_sel1))  read_data1 = write_data;
  end

  always_comb begin
    read_data2 = regs[read_sel2];
    if (read_sel2 == '0)                            read_data2 = '0;
    else if (write_en && (write_sel == read_sel2))  read_data2 = write_data;
  end

endmodule

// File: rtl/s1_decode_stage.sv
// Stage-1 decode plus ID/EX register; one cycle S1_Instr -> S2_*.
// Stall holds the S2 register, Flush (higher priority) loads a bubble.
module s1_decode_stage
  import s1_decode_pkg::*;
#(
  parameter int DATA_WIDTH      = S1_DATA_W,
  parameter int REG_ADDR_WIDTH  = S1_RADDR_W,
  parameter int IMMEDIATE_WIDTH = S1_IMM_W,
  parameter int ALUOP_WIDTH     = S1_ALUOP_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                S1_Instr,
  input  logic                       S1_Valid,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic [REG_ADDR_WIDTH-1:0]  WB_WriteSelect,
  input  logic                       WB_WriteEnable,
  input  logic [DATA_WIDTH-1:0]      WB_WriteData,
  output logic [DATA_WIDTH-1:0]      S2_ReadData1,
  output logic [DATA_WIDTH-1:0]      S2_ReadData2,
  output logic [IMMEDIATE_WIDTH-1:0] S2_Imm,
  output logic                       S2_DataSource,
  output logic [ALUOP_WIDTH-1:0]     S2_ALUOp,
  output logic [REG_ADDR_WIDTH-1:0]  S2_WriteSelect,
  output logic                       S2_WriteEnable,
  output logic                       S2_Valid
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      rd1;
    logic [DATA_WIDTH-1:0]      rd2;
    logic [IMMEDIATE_WIDTH-1:0] imm;
    logic                       dsrc;
    logic [ALUOP_WIDTH-1:0]     aluop;
    logic [REG_ADDR_WIDTH-1:0]  wsel;
    logic                       we;
    logic                       vld;
  } s2_t;

  logic [S1_OPCODE_W-1:0]    opcode;
  logic [REG_ADDR_WIDTH-1:0] rs_sel;
  logic [REG_ADDR_WIDTH-1:0] rt_sel;
  logic [DATA_WIDTH-1:0]     rf_rd1;
  logic [DATA_WIDTH-1:0]     rf_rd2;
  s2_t                       dec;
  s2_t                       s2;

  assign opcode = S1_Instr[OPC_LSB +: S1_OPCODE_W];
  assign rs_sel = S1_Instr[RS_LSB +: REG_ADDR_WIDTH];
  assign rt_sel = S1_Instr[RT_LSB +: REG_ADDR_WIDTH];

  regfile_32x32 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_sel1  (rs_sel),
    .read_sel2  (rt_sel),
    .read_data1 (rf_rd1),
    .read_data2 (rf_rd2),
    .write_sel  (WB_WriteSelect),
    .write_en   (WB_WriteEnable),
    .write_data (WB_WriteData)
  );

  // Non-ALU opcode classes decode as NOPs: only the write-enable is suppressed
  always_comb begin
    dec       = '0;
    dec.rd1   = rf_rd1;
    dec.rd2   = rf_rd2;
    dec.imm   = S1_Instr[IMM_LSB +: IMMEDIATE_WIDTH];
    dec.dsrc  = opcode[OPC_DSRC_BIT];
    dec.aluop = opcode[ALUOP_WIDTH-1:0];
    dec.wsel  = S1_Instr[RD_LSB +: REG_ADDR_WIDTH];
    dec.we    = S1_Valid && (opcode[OPC_CLASS_LSB +: 2] == OPC_CLASS_ALU);
    dec.vld   = S1_Valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s2 <= '0;
    else if (Flush)  s2 <= '0;
    else if (!Stall) s2 <= dec;
  end

  assign S2_ReadData1   = s2.rd1;
  assign S2_ReadData2   = s2.rd2;
  assign S2_Imm         = s2.imm;
  assign S2_DataSource  = s2.dsrc;
  assign S2_ALUOp       = s2.aluop;
  assign S2_WriteSelect = s2.wsel;
  assign S2_WriteEnable = s2.we;
  assign S2_Valid       = s2.vld;

endmodule

// File: tb/tb_s1_decode_stage.sv
// Randomized + directed bench for s1_decode_stage against a field-level reference model.
module tb_s1_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] S1_Instr;
  logic        S1_Valid;
  logic        Stall;
  logic        Flush;
  logic [4:0]  WB_WriteSelect;
  logic        WB_WriteEnable;
  logic [31:0] WB_WriteData;
  logic [31:0] S2_ReadData1;
  logic [31:0] S2_ReadData2;
  logic [15:0] S2_Imm;
  logic        S2_DataSource;
  logic [2:0]  S2_ALUOp;
  logic [4:0]  S2_WriteSelect;
  logic        S2_WriteEnable;
  logic        S2_Valid;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural register contents and expected S2 fields
  logic [31:0] mrf [32];
  logic [31:0] e_rd1, e_rd2;
  logic [15:0] e_imm;
  logic        e_ds, e_we, e_vld;
  logic [2:0]  e_alu;
  logic [4:0]  e_ws;

  always #5 clk = ~clk;

  s1_decode_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .S1_Instr       (S1_Instr),
    .S1_Valid       (S1_Valid),
    .Stall          (Stall),
    .Flush          (Flush),
    .WB_WriteSelect (WB_WriteSelect),
    .WB_WriteEnable (WB_WriteEnable),
    .WB_WriteData   (WB_WriteData),
    .S2_ReadData1   (S2_ReadData1),
    .S2_ReadData2   (S2_ReadData2),
    .S2_Imm         (S2_Imm),
    .S2_DataSource  (S2_DataSource),
    .S2_ALUOp       (S2_ALUOp),
    .S2_WriteSelect (S2_WriteSelect),
    .S2_WriteEnable (S2_WriteEnable),
    .S2_Valid       (S2_Valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {opc, rd, rs, imm};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] sel);
    if (sel == 5'd0) return 32'd0;
    if (WB_WriteEnable && WB_WriteSelect == sel) return WB_WriteData;
    return mrf[sel];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rd1"}, 64'(S2_ReadData1),   64'(e_rd1));
    check({tag, ".rd2"}, 64'(S2_ReadData2),   64'(e_rd2));
    check({tag, ".imm"}, 64'(S2_Imm),         64'(e_imm));
    check({tag, ".ds"},  64'(S2_DataSource),  64'(e_ds));
    check({tag, ".alu"}, 64'(S2_ALUOp),       64'(e_alu));
    check({tag, ".ws"},  64'(S2_WriteSelect), 64'(e_ws));
    check({tag, ".we"},  64'(S2_WriteEnable), 64'(e_we));
    check({tag, ".vld"}, 64'(S2_Valid),       64'(e_vld));
  endtask

  task automatic clear_expect();
    e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_ds = 1'b0;
    e_alu = '0; e_ws = '0; e_we = 1'b0; e_vld = 1'b0;
  endtask

  // One clock: drive at negedge, predict, update model on posedge, check #1 later
  task automatic step(input string tag, input logic [31:0] instr, input logic vld,
                      input logic stl, input logic fls, input logic [4:0] wsel,
                      input logic wen, input logic [31:0] wdat);
    @(negedge clk);
    S1_Instr = instr; S1_Valid = vld; Stall = stl; Flush = fls;
    WB_WriteSelect = wsel; WB_WriteEnable = wen; WB_WriteData = wdat;
    #1;
    if (fls) begin
      clear_expect();
    end else if (!stl) begin
      e_rd1 = model_read(instr[20:16]);
      e_rd2 = model_read(instr[15:11]);
      e_imm = instr[15:0];
      e_ds  = instr[29];
      e_alu = instr[28:26];
      e_ws  = instr[25:21];
      e_we  = vld && (instr[31:30] == 2'b00);
      e_vld = vld;
    end
    @(posedge clk);
    if (wen && wsel != 5'd0) mrf[wsel] = wdat;
    #1;
    check_all(tag);
  endtask

  task automatic idle_step(input string tag, input logic [31:0] instr);
    step(tag, instr, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] instr_a;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    clear_expect();
    rst_n = 1'b0; S1_Instr = '0; S1_Valid = 1'b0; Stall = 1'b0; Flush = 1'b0;
    WB_WriteSelect = '0; WB_WriteEnable = 1'b0; WB_WriteData = '0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Write R5 while reading it: bypass gives the new value with no extra latency
    step("bypass", mk(6'b000001, 5'd3, 5'd5, 16'h0000), 1'b1, 1'b0, 1'b0,
         5'd5, 1'b1, 32'hDEADBEEF);
    check("bypass_r5", 64'(S2_ReadData1), 64'h0000_0000_DEAD_BEEF);

    // R0 writes are dropped
    step("r0_wr", mk(6'b000000, 5'd1, 5'd0, 16'h0000), 1'b1, 1'b0, 1'b0,
         5'd0, 1'b1, 32'hFFFFFFFF);
    idle_step("r0_rd", mk(6'b000000, 5'd1, 5'd0, 16'h0000));
    check("r0_zero", 64'(S2_ReadData1), 64'd0);

    // Immediate path
    idle_step("imm", mk(6'b001010, 5'd9, 5'd5, 16'h1234));
    check("imm_ds",  64'(S2_DataSource),  64'd1);
    check("imm_alu", 64'(S2_ALUOp),       64'd2);
    check("imm_val", 64'(S2_Imm),         64'h1234);
    check("imm_we",  64'(S2_WriteEnable), 64'd1);

    // Stall holds A for three cycles even with changing input and write-backs
    instr_a = mk(6'b000110, 5'd4, 5'd5, 16'h5800);
    idle_step("stall_a", instr_a);
    for (int i = 0; i < 3; i++)
      step("stall_hold", $urandom, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, $urandom);
    check("stall_imm", 64'(S2_Imm), 64'h5800);
    idle_step("stall_rel", mk(6'b010111, 5'd7, 5'd2, 16'hABCD));
    check("stall_rel_we", 64'(S2_WriteEnable), 64'd0);

    // Flush beats Stall; the concurrent write-back still lands
    idle_step("pre_flush", mk(6'b000011, 5'd6, 5'd5, 16'h0800));
    step("flush_stall", mk(6'b000011, 5'd6, 5'd5, 16'h0800), 1'b1, 1'b1, 1'b1,
         5'd7, 1'b1, 32'h55AA_33CC);
    check("flush_vld", 64'(S2_Valid), 64'd0);
    idle_step("flush_wb", mk(6'b000000, 5'd1, 5'd7, 16'h0000));
    check("flush_wb_r7", 64'(S2_ReadData1), 64'h55AA_33CC);

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      step("rand", $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 1), $urandom);

    // Asynchronous reset mid-cycle, during a stall
    @(negedge clk);
    Stall = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    clear_expect();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      idle_step("post_rst", mk(6'b000000, 5'd1, 5'(r), {5'(r), 11'd0}));
      check("post_rst_rd1", 64'(S2_ReadData1), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/s1_decode_stage.md
Name: s1_decode_stage

Overview:
Stage-1 decode and ID/EX pipeline register of the pipelined datapath.
- Splits the S1 instruction into fields.
- Reads two operands from a 32x32 register file, which is written by the write-back stage.
- Registers the decoded results into the S2_* signals that feed the stage-2 ALU-source mux and the ALU.
- Supports stall (hold) and flush (bubble insertion) from hazard control.

Parameters:
DATA_WIDTH, 32, register/operand width
REG_ADDR_WIDTH, 5, register select width (2^5 = 32 registers)
IMMEDIATE_WIDTH, 16, immediate field width
ALUOP_WIDTH, 3, ALU operation code width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
S1_Instr  input  32  instruction from IF/ID register
S1_Valid  input  1  S1_Instr holds a real instruction
Stall  input  1  hold all S2 outputs this cycle
Flush  input  1  load a bubble into S2 this cycle
WB_WriteSelect  input  5  write-back destination register
WB_WriteEnable  input  1  write-back strobe
WB_WriteData  input  32  write-back data
S2_ReadData1  output  32  operand A
S2_ReadData2  output  32  operand B (register path of ALU-source mux)
S2_Imm  output  16  raw immediate field
S2_DataSource  output  1  1 = ALU B uses immediate, 0 = ReadData2
S2_ALUOp  output  3  ALU operation
S2_WriteSelect  output  5  destination register
S2_WriteEnable  output  1  instruction writes back
S2_Valid  output  1  S2 holds a real instruction

Behaviour:
- Instruction fields:
  - opcode = [31:26]
  - rd = [25:21]
  - rs = [20:16]
  - rt = [15:11]
  - imm = [15:0]
- Decode, combinational in S1:
  - ALUOp = opcode[2:0]
  - DataSource = opcode[3]
  - WriteEnable = S1_Valid and opcode[5:4] == 2'b00
  - opcode[5:4] != 00 is a NOP: WriteEnable = 0, all other fields pass through unchanged.
- Register file:
  - 32 entries of 32 bits; R0 always reads 0 and writes to it are ignored.
  - Write on rising clk when WB_WriteEnable = 1.
  - Write-first bypass: if WB_WriteEnable = 1, WB_WriteSelect == read select, and select != 0, the read returns WB_WriteData in the same cycle.
  - Register file writes occur regardless of Stall/Flush.
- Pipeline register, per rising clk, in priority order:
  1. Flush = 1: every S2 output is loaded with 0. This includes S2_Valid = 0, S2_WriteEnable = 0 and S2_DataSource = 0.
  2. Stall = 1: every S2 output holds its value.
  3. Otherwise: load the decoded S1 values and the bypassed read data.
  - Flush has priority over Stall.
- Latency: one cycle from S1_Instr to S2_*.
- Stall semantics: held S2_ReadData values are not refreshed by write-backs during the stall. Forwarding for that case lives downstream.
- Reset (rst_n low, asynchronous):
  - All S2 outputs go to 0 and all 32 registers are cleared to 0.
  - A reset mid-stall or mid-flush discards the pending state.
  - The first clk after rst_n rises behaves normally.
- S1_Valid = 0 with no Flush: S2_Valid = 0 and S2_WriteEnable = 0; the other fields are loaded as decoded.

Decomposition:
- Package s1_decode_pkg holds:
  - field bit positions
  - opcode class constants (OPC_CLASS_ALU = 2'b00)
  - width constants
- Sub-module regfile_32x32: two async read ports, one sync write port, R0 zero, write-first bypass, async active-low reset.
- Decode and the pipeline register stay in s1_decode_stage.

Test Plan:
- Reset: drive rst_n low mid-cycle -> all S2_* = 0 immediately; after release, reading R1..R31 returns 0.
- Write/bypass: WB writes R5 = 0xDEADBEEF while S1_Instr has rs = 5 -> next cycle S2_ReadData1 = 0xDEADBEEF, with no extra cycle of latency.
- R0: WB writes R0 = 0xFFFFFFFF, then read rs = 0 -> S2_ReadData1 = 0.
- Immediate path: opcode = 6'b001010, imm = 0x1234, S1_Valid = 1 -> S2_DataSource = 1, S2_ALUOp = 3'b010, S2_Imm = 0x1234, S2_WriteEnable = 1.
- Stall: load instruction A, then assert Stall for 3 cycles while S1_Instr changes -> S2_* hold A's values; on release, the next instruction loads.
- Flush vs Stall: assert Flush and Stall together with a valid S2 -> S2_Valid = 0, S2_WriteEnable = 0, all data 0; a WB write issued in the same cycle still lands in the register file.
